esi_manifest_reader: RTL

- Synthesizable host-facing read port for the zlib-compressed ESI JSON manifest. It is the hardware-side counterpart to the cosim manifest push.
- Software issues MMIO-style read requests. The block returns the manifest size header and the compressed bytes packed into 64-bit words.
- Sits behind the ESI MMIO/read-request fabric, instantiated once per design, with the compressed manifest bytes supplied as a constant bus.

---
 rtl/esi_manifest_reader.sv | 110 +++++++++++
 1 files changed

// File: rtl/esi_manifest_reader.sv
// esi_manifest_reader
// Host-facing read port for the compressed ESI manifest. Word 0 is a
// {MAGIC, size} header and words 1..NW carry the manifest bytes, little-endian
// within each 64-bit word. Misaligned or out-of-range reads return an error
// response with zero data.
//
// Handshake (both channels): a transfer happens on a rising edge where
// valid && ready are both high. Producers hold valid and payload stable until
// that transfer; ready may change freely. Here req_ready = !resp_valid ||
// resp_ready, so a single response register gives one read per cycle under
// continuous resp_ready and stalls cleanly under backpressure.
module esi_manifest_reader #(
  parameter int          COMPRESSED_MANIFEST_SIZE = 16,
  parameter int          ADDR_WIDTH               = 32,
  parameter logic [31:0] MAGIC                    = 32'h4D414E49
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [8*COMPRESSED_MANIFEST_SIZE-1:0] compressed_manifest,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [ADDR_WIDTH-1:0]                 req_addr,
  output logic                                  resp_valid,
  input  logic                                  resp_ready,
  output logic [63:0]                           resp_data,
  output logic                                  resp_error,
  output logic [31:0]                           reads_served
);

  // Number of data words; the last one is zero-padded past the final byte.
  localparam int NW          = (COMPRESSED_MANIFEST_SIZE + 7) / 8;
  localparam int PADDED_BITS = 64 * NW;

  // Highest legal word index, at full address width so that any set upper
  // address bit lands as out of range without extra masking.
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NW);

  localparam logic [63:0] HEADER = {MAGIC, 32'(COMPRESSED_MANIFEST_SIZE)};

  logic [ADDR_WIDTH-1:0]  word_idx;
  logic                   misaligned;
  logic                   out_of_range;
  logic [PADDED_BITS-1:0] padded;
  logic [63:0]            word_data;
  logic [63:0]            next_data;
  logic                   next_error;
  logic                   accept;
  logic                   consume;

  // Handshake qualifiers.
  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready;
  assign consume   = resp_valid && resp_ready;

  // Address decode: byte address to word index plus error classification.
  assign word_idx     = {3'b000, req_addr[ADDR_WIDTH-1:3]};
  assign misaligned   = |req_addr[2:0];
  assign out_of_range = word_idx > LAST_WORD;

  // Zero-extend the byte bus to a whole number of 64-bit words.
  always_comb begin
    padded = '0;
    padded[8*COMPRESSED_MANIFEST_SIZE-1:0] = compressed_manifest;
  end

  // Word-indexed mux straight off the live byte bus; no stored copy.
  always_comb begin
    word_data = '0;
    for (int w = 1; w <= NW; w++) begin
      if (word_idx == ADDR_WIDTH'(w)) begin
        word_data = padded[64*(w-1) +: 64];
      end
    end
    if (word_idx == '0) begin
      word_data = HEADER;
    end
  end

  // Error responses always carry zero data.
  always_comb begin
    next_error = misaligned || out_of_range;
    next_data  = next_error ? 64'd0 : word_data;
  end

  // Response register: load on accept, drop valid on a consume with no
  // new request behind it, otherwise hold everything stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_data  <= 64'd0;
      resp_error <= 1'b0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_data  <= next_data;
      resp_error <= next_error;
    end else if (consume) begin
      resp_valid <= 1'b0;
    end
  end

  // Completed-response counter, error responses included; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      reads_served <= 32'd0;
    end else if (consume) begin
      reads_served <= reads_served + 32'd1;
    end
  end

endmodule
